// File: rtl/ahb_rr_arbiter.sv
// ahb_rr_arbiter
// Round-robin AHB arbiter sharing one subordinate path among NUM_MGR managers.
// Grants are held across fixed-length bursts, SPLIT responses mask the
// data-phase owner until its i_hsplit pulse, and the bus parks on DEFAULT_MGR
// when nobody eligible is requesting.
// Optional feature macro: AHB_ARB_HLOCK_EN adds i_hlock / o_hmastlock so a
// manager can hold the bus across several transfers (locked sequences).

module ahb_rr_arbiter #(
  parameter int NUM_MGR     = 4,
  parameter int DEFAULT_MGR = 0,
  parameter int MW          = $clog2(NUM_MGR)
) (
  input  logic               i_hclk,
  input  logic               i_hreset_n,
  input  logic [NUM_MGR-1:0] i_hbusreq,
  input  logic [NUM_MGR-1:0] i_hsplit,
  input  logic [1:0]         i_htrans,
  input  logic [2:0]         i_hburst,
  input  logic               i_hready,
  input  logic [1:0]         i_hresp,
`ifdef AHB_ARB_HLOCK_EN
  input  logic [NUM_MGR-1:0] i_hlock,
  output logic               o_hmastlock,
`endif
  output logic [NUM_MGR-1:0] o_hgrant,
  output logic [MW-1:0]      o_hmaster
);

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  localparam logic [MW-1:0]      DEF_IDX   = MW'(DEFAULT_MGR);
  localparam logic [NUM_MGR-1:0] ONE_BIT   = {{(NUM_MGR-1){1'b0}}, 1'b1};
  localparam logic [NUM_MGR-1:0] DEF_GRANT = ONE_BIT << DEFAULT_MGR;

  typedef enum logic [1:0] {
    PARK  = 2'd0,
    OWN   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t               state;
  logic [4:0]           r_rem;
  logic [NUM_MGR-1:0]   r_mask;
  logic [MW-1:0]        r_last;
  logic [MW-1:0]        r_dmaster;

  logic [MW-1:0]        grant_idx;
  logic [4:0]           reload;
  logic [4:0]           rem_nxt;
  logic [NUM_MGR-1:0]   eligible;
  logic                 rr_found;
  logic [MW-1:0]        rr_idx;
  logic [MW-1:0]        cand;
  logic [NUM_MGR-1:0]   new_grant;
  logic                 owner_masked;
  logic                 err_cycle;
  logic                 split_first;
  logic [NUM_MGR-1:0]   split_set;
  logic                 lock_hold;
  logic                 arb_point;

`ifdef AHB_ARB_HLOCK_EN
  logic                 r_dlock;
`endif

  // Convert the one-hot grant into the index of the manager currently granted
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (o_hgrant[i]) grant_idx = MW'(i);
    end
  end

  // Beats remaining after the first beat of a fixed burst; SINGLE/INCR have no fixed tail
  always_comb begin
    reload = 5'd0;
    unique case (i_hburst[2:1])
      2'b00:   reload = 5'd0;
      2'b01:   reload = 5'd3;
      2'b10:   reload = 5'd7;
      default: reload = 5'd15;
    endcase
  end

  // Beat counter value after this accept, derived from the transfer type presented
  always_comb begin
    rem_nxt = 5'd0;
    unique case (i_htrans)
      HTRANS_IDLE:   rem_nxt = 5'd0;
      HTRANS_BUSY:   rem_nxt = r_rem;
      HTRANS_NONSEQ: rem_nxt = reload;
      default:       rem_nxt = (r_rem != 5'd0) ? (r_rem - 5'd1) : 5'd0;
    endcase
  end

  // Round-robin search starting just after the last winner, so the last winner is checked last
  always_comb begin
    eligible = i_hbusreq & ~r_mask;
    rr_found = 1'b0;
    rr_idx   = DEF_IDX;
    cand     = '0;
    for (int k = 1; k <= NUM_MGR; k++) begin
      cand = MW'((int'(r_last) + k) % NUM_MGR);
      if (!rr_found && eligible[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
    new_grant = rr_found ? (ONE_BIT << rr_idx) : DEF_GRANT;
  end

  // Response decode and arbitration-point qualification
  always_comb begin
    err_cycle    = !i_hready && (i_hresp != HRESP_OKAY);
    split_first  = !i_hready && (i_hresp == HRESP_SPLIT);
    split_set    = split_first ? (ONE_BIT << r_dmaster) : '0;
    owner_masked = r_mask[grant_idx];
`ifdef AHB_ARB_HLOCK_EN
    lock_hold    = i_hlock[grant_idx];
`else
    lock_hold    = 1'b0;
`endif
    arb_point    = i_hready && !lock_hold && ((rem_nxt == 5'd0) || owner_masked);
  end

  // Main arbiter state: grant, owner pipeline, burst tracking and RR pointer
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state     <= PARK;
      o_hgrant  <= DEF_GRANT;
      o_hmaster <= DEF_IDX;
      r_dmaster <= DEF_IDX;
      r_rem     <= 5'd0;
      r_last    <= DEF_IDX;
`ifdef AHB_ARB_HLOCK_EN
      o_hmastlock <= 1'b0;
      r_dlock     <= 1'b0;
`endif
    end else if (err_cycle) begin
      r_rem <= 5'd0;
      if (state == BURST) state <= OWN;
    end else if (i_hready) begin
      r_dmaster <= o_hmaster;
      o_hmaster <= grant_idx;
`ifdef AHB_ARB_HLOCK_EN
      r_dlock     <= o_hmastlock;
      o_hmastlock <= i_hlock[grant_idx];
`endif
      if (arb_point) begin
        r_rem    <= 5'd0;
        o_hgrant <= new_grant;
        if (rr_found) r_last <= rr_idx;
        state    <= rr_found ? OWN : PARK;
      end else begin
        r_rem <= rem_nxt;
        if (rem_nxt != 5'd0) begin
          state <= BURST;
        end else begin
          state <= (state == PARK) ? PARK : OWN;
        end
      end
    end
  end

  // Split mask: set on the first SPLIT cycle for the data-phase owner, cleared by i_hsplit; set wins
  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_mask <= '0;
    end else begin
      r_mask <= (r_mask & ~i_hsplit) | split_set;
    end
  end

`ifdef AHB_ARB_HLOCK_EN
  // A SPLIT on a locked transfer is a subordinate protocol violation; flag it in simulation
  always @(posedge i_hclk) begin
    if (i_hreset_n && split_first) begin
      assert (!r_dlock)
        else $error("ahb_rr_arbiter: SPLIT response to locked manager %0d", r_dmaster);
    end
  end
`endif

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// tb_ahb_rr_arbiter
// Directed-vector bench for ahb_rr_arbiter. Each vector pushes its hand-computed
// grant/master expectation into a scoreboard queue; a monitor pops and compares
// just after every rising edge. Define AHB_ARB_HLOCK_EN to add the lock test.

module tb_ahb_rr_arbiter;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] NONSEQ = 2'd2;
  localparam logic [1:0] SEQ    = 2'd3;

  localparam logic [1:0] OKAY  = 2'd0;
  localparam logic [1:0] ERROR = 2'd1;
  localparam logic [1:0] RETRY = 2'd2;
  localparam logic [1:0] SPLIT = 2'd3;

  localparam logic [2:0] SINGLE = 3'd0;
  localparam logic [2:0] INCR4  = 3'd3;
  localparam logic [2:0] INCR8  = 3'd5;
  localparam logic [2:0] INCR16 = 3'd7;

  typedef struct {
    string      name;
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
  } exp_t;

  logic       hclk = 1'b0;
  logic       hreset_n;
  logic [3:0] hbusreq;
  logic [3:0] hsplit;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [1:0] hresp;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
`ifdef AHB_ARB_HLOCK_EN
  logic [3:0] hlock;
  logic       hmastlock;
`endif

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  ahb_rr_arbiter #(
    .NUM_MGR     (4),
    .DEFAULT_MGR (0)
  ) dut (
    .i_hclk      (hclk),
    .i_hreset_n  (hreset_n),
    .i_hbusreq   (hbusreq),
    .i_hsplit    (hsplit),
    .i_htrans    (htrans),
    .i_hburst    (hburst),
    .i_hready    (hready),
    .i_hresp     (hresp),
`ifdef AHB_ARB_HLOCK_EN
    .i_hlock     (hlock),
    .o_hmastlock (hmastlock),
`endif
    .o_hgrant    (hgrant),
    .o_hmaster   (hmaster)
  );

  // 100 MHz bus clock
  always #5 hclk = ~hclk;

  function automatic exp_t mk_exp(input string name, input logic [3:0] g,
                                  input logic [1:0] m, input logic l);
    exp_t e;
    e.name   = name;
    e.grant  = g;
    e.master = m;
    e.lock   = l;
    return e;
  endfunction

  task automatic checkOutput(input exp_t e);
    checks++;
    if (hgrant !== e.grant) begin
      errors++;
      $display("[TB] FAIL %s grant: got %b expected %b", e.name, hgrant, e.grant);
    end
    checks++;
    if (hmaster !== e.master) begin
      errors++;
      $display("[TB] FAIL %s master: got %0d expected %0d", e.name, hmaster, e.master);
    end
`ifdef AHB_ARB_HLOCK_EN
    checks++;
    if (hmastlock !== e.lock) begin
      errors++;
      $display("[TB] FAIL %s mastlock: got %b expected %b", e.name, hmastlock, e.lock);
    end
`endif
  endtask

  // Drive one bus cycle on the falling edge and queue what the next rising edge must produce
  task automatic applyStimulus(input string name, input logic [3:0] req, input logic [3:0] spl,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic rdy, input logic [1:0] resp,
                               input logic [3:0] exp_g, input logic [1:0] exp_m);
    @(negedge hclk);
    hbusreq = req;
    hsplit  = spl;
    htrans  = trans;
    hburst  = burst;
    hready  = rdy;
    hresp   = resp;
    sb_q.push_back(mk_exp(name, exp_g, exp_m, 1'b0));
  endtask

`ifdef AHB_ARB_HLOCK_EN
  task automatic applyLockStimulus(input string name, input logic [3:0] req, input logic [3:0] lck,
                                   input logic [1:0] trans, input logic [2:0] burst,
                                   input logic [3:0] exp_g, input logic [1:0] exp_m,
                                   input logic exp_l);
    @(negedge hclk);
    hbusreq = req;
    hlock   = lck;
    hsplit  = 4'b0000;
    htrans  = trans;
    hburst  = burst;
    hready  = 1'b1;
    hresp   = OKAY;
    sb_q.push_back(mk_exp(name, exp_g, exp_m, exp_l));
  endtask
`endif

  task automatic driveIdle();
    hbusreq = 4'b0000;
    hsplit  = 4'b0000;
    htrans  = IDLE;
    hburst  = SINGLE;
    hready  = 1'b1;
    hresp   = OKAY;
`ifdef AHB_ARB_HLOCK_EN
    hlock   = 4'b0000;
`endif
  endtask

  // Wait (bounded) until the monitor has consumed every queued expectation
  task automatic drainScoreboard();
    int n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      @(negedge hclk);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic doReset();
    drainScoreboard();
    @(negedge hclk);
    hreset_n = 1'b0;
    driveIdle();
    #1;
    checkOutput(mk_exp("reset", 4'b0001, 2'd0, 1'b0));
    @(negedge hclk);
    hreset_n = 1'b1;
  endtask

  // Monitor: compare the oldest expectation just after each rising edge
  initial begin
    forever begin
      @(posedge hclk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    hreset_n = 1'b0;
    driveIdle();
    repeat (2) @(negedge hclk);
    checkOutput(mk_exp("reset_init", 4'b0001, 2'd0, 1'b0));
    hreset_n = 1'b1;

    $display("[TB] park on default manager with no requests");
    for (int i = 0; i < 20; i++)
      applyStimulus("park", 4'b0000, 4'b0000, IDLE, SINGLE, 1'b1, OKAY, 4'b0001, 2'd0);

    $display("[TB] round-robin between managers 1 and 2");
    doReset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus("rr_to1", 4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY, 4'b0010,
                    (i == 0) ? 2'd0 : 2'd2);
      applyStimulus("rr_to2", 4'b0110, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY, 4'b0100, 2'd1);
    end

    $display("[TB] INCR8 from manager 1 with stalls while manager 3 waits");
    doReset();
    applyStimulus("b8_req",  4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY, 4'b0010, 2'd0);
    applyStimulus("b8_own",  4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_ns",   4'b1010, 4'b0000, NONSEQ, INCR8,  1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s1w",  4'b1010, 4'b0000, SEQ,    INCR8,  1'b0, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s1",   4'b1010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s2",   4'b1010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s3w",  4'b1010, 4'b0000, SEQ,    INCR8,  1'b0, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s3",   4'b1010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s4",   4'b1010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s5",   4'b1010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s6w",  4'b1010, 4'b0000, SEQ,    INCR8,  1'b0, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_s6",   4'b1010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY, 4'b0010, 2'd1);
    applyStimulus("b8_last", 4'b1010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY, 4'b1000, 2'd1);
    applyStimulus("b8_m3",   4'b1000, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY, 4'b1000, 2'd3);

    $display("[TB] SPLIT masking of manager 2");
    doReset();
    applyStimulus("sp_req",   4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0100, 2'd0);
    applyStimulus("sp_own",   4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0100, 2'd2);
    applyStimulus("sp_ns",    4'b0110, 4'b0000, NONSEQ, INCR4,  1'b1, OKAY,  4'b0100, 2'd2);
    applyStimulus("sp_s1",    4'b0110, 4'b0000, SEQ,    INCR4,  1'b1, OKAY,  4'b0100, 2'd2);
    applyStimulus("sp_c1",    4'b0110, 4'b0000, SEQ,    INCR4,  1'b0, SPLIT, 4'b0100, 2'd2);
    applyStimulus("sp_c2",    4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, SPLIT, 4'b0010, 2'd2);
    applyStimulus("sp_m1",    4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0010, 2'd1);
    applyStimulus("sp_ign",   4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd1);
    applyStimulus("sp_clr",   4'b0100, 4'b0100, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("sp_back",  4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0100, 2'd0);
    applyStimulus("sp_rr1",   4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0010, 2'd2);
    applyStimulus("sp_rr2",   4'b0110, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0100, 2'd1);
    applyStimulus("sp_setw1", 4'b0110, 4'b0100, SEQ,    INCR4,  1'b0, SPLIT, 4'b0100, 2'd1);
    applyStimulus("sp_setw2", 4'b0100, 4'b0000, IDLE,   SINGLE, 1'b1, SPLIT, 4'b0001, 2'd2);

    $display("[TB] INCR16 from manager 0 ends with ERROR");
    doReset();
    applyStimulus("er_req", 4'b0001, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("er_ns",  4'b0011, 4'b0000, NONSEQ, INCR16, 1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("er_s1",  4'b0011, 4'b0000, SEQ,    INCR16, 1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("er_s2",  4'b0011, 4'b0000, SEQ,    INCR16, 1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("er_c1",  4'b0011, 4'b0000, SEQ,    INCR16, 1'b0, ERROR, 4'b0001, 2'd0);
    applyStimulus("er_c2",  4'b0011, 4'b0000, IDLE,   SINGLE, 1'b1, ERROR, 4'b0010, 2'd0);

    $display("[TB] RETRY clears the counter without masking");
    doReset();
    applyStimulus("rt_req", 4'b0001, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("rt_ns",  4'b0101, 4'b0000, NONSEQ, INCR8,  1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("rt_s1",  4'b0101, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0001, 2'd0);
    applyStimulus("rt_c1",  4'b0101, 4'b0000, SEQ,    INCR8,  1'b0, RETRY, 4'b0001, 2'd0);
    applyStimulus("rt_c2",  4'b0101, 4'b0000, BUSY,   INCR8,  1'b1, RETRY, 4'b0100, 2'd0);
    applyStimulus("rt_m0",  4'b0101, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd2);

    $display("[TB] asynchronous reset in the middle of a burst");
    doReset();
    applyStimulus("ar_req", 4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY, 4'b0010, 2'd0);
    applyStimulus("ar_ns",  4'b0010, 4'b0000, NONSEQ, INCR4,  1'b1, OKAY, 4'b0010, 2'd1);
    drainScoreboard();
    @(negedge hclk);
    hbusreq  = 4'b0010;
    htrans   = SEQ;
    hburst   = INCR4;
    hready   = 1'b1;
    hresp    = OKAY;
    hreset_n = 1'b0;
    #1;
    checkOutput(mk_exp("ar_async", 4'b0001, 2'd0, 1'b0));
    @(negedge hclk);
    hreset_n = 1'b1;
    sb_q.push_back(mk_exp("ar_seq_after", 4'b0010, 2'd0, 1'b0));
    drainScoreboard();

`ifdef AHB_ARB_HLOCK_EN
    $display("[TB] locked INCR4 pair from manager 3");
    doReset();
    applyLockStimulus("lk_req", 4'b1000, 4'b1000, IDLE, SINGLE, 4'b1000, 2'd0, 1'b0);
    applyLockStimulus("lk_own", 4'b1001, 4'b1000, IDLE, SINGLE, 4'b1000, 2'd3, 1'b1);
    for (int b = 0; b < 2; b++) begin
      applyLockStimulus("lk_ns", 4'b1001, 4'b1000, NONSEQ, INCR4, 4'b1000, 2'd3, 1'b1);
      for (int s = 0; s < 3; s++)
        applyLockStimulus("lk_seq", 4'b1001, 4'b1000, SEQ, INCR4, 4'b1000, 2'd3, 1'b1);
    end
    applyLockStimulus("lk_drop", 4'b1001, 4'b0000, IDLE, SINGLE, 4'b0001, 2'd3, 1'b0);
    applyLockStimulus("lk_m0",   4'b0001, 4'b0000, IDLE, SINGLE, 4'b0001, 2'd0, 1'b0);
`endif

    drainScoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
